// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with saturated |Gx|+|Gy|; result 1 cycle after the accepting beat.
// Single output slot: input stalls (ready_o low) only while a result is held and ready_i is low.
module sobel_edge_stream #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] gray_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic [7:0] edge_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_done_o
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [7:0]         lb1 [IMG_WIDTH];
    logic [7:0]         lb2 [IMG_WIDTH];
    logic [7:0]         win [3][3];
    logic [7:0]         nwin [3][3];
    logic               accept;
    logic               interior;
    logic               last_pix;
    logic signed [10:0] gx;
    logic signed [10:0] gy;
    logic signed [10:0] ax;
    logic signed [10:0] ay;
    logic [11:0]        mag;
    logic [7:0]         sat;
    logic               out_vld;
    logic               out_last;
    logic [7:0]         out_edge;

    function automatic logic signed [10:0] zx(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    assign ready_o      = !out_vld || ready_i;
    assign accept       = valid_i && ready_o;
    assign interior     = (row >= RW'(2)) && (col >= CW'(2));
    assign last_pix     = (row == ROW_LAST) && (col == COL_LAST);
    assign valid_o      = out_vld;
    assign edge_o       = out_edge;
    assign frame_done_o = out_vld && ready_i && out_last;

    // Window as it will look after this beat's shift; the result is computed from it directly.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nwin[r][0] = win[r][1];
            nwin[r][1] = win[r][2];
        end
        nwin[0][2] = lb2[col];
        nwin[1][2] = lb1[col];
        nwin[2][2] = gray_i;
    end

    always_comb begin
        gx  = (zx(nwin[0][2]) + (zx(nwin[1][2]) <<< 1) + zx(nwin[2][2]))
            - (zx(nwin[0][0]) + (zx(nwin[1][0]) <<< 1) + zx(nwin[2][0]));
        gy  = (zx(nwin[2][0]) + (zx(nwin[2][1]) <<< 1) + zx(nwin[2][2]))
            - (zx(nwin[0][0]) + (zx(nwin[0][1]) <<< 1) + zx(nwin[0][2]));
        ax  = gx[10] ? -gx : gx;
        ay  = gy[10] ? -gy : gy;
        mag = {1'b0, ax} + {1'b0, ay};
        sat = (mag > 12'd255) ? 8'hFF : mag[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers are overwritten before use, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb1[col] <= gray_i;
            lb2[col] <= lb1[col];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= 8'd0;
        end else if (accept) begin
            win <= nwin;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld  <= 1'b0;
            out_edge <= 8'd0;
            out_last <= 1'b0;
        end else if (accept && interior) begin
            out_vld  <= 1'b1;
            out_edge <= sat;
            out_last <= last_pix;
        end else if (ready_i) begin
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream: 4x4 instance for the main scenarios, 5x3 instance for non-square geometry.
module tb_sobel_edge_stream;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] gray;
    logic       vin;
    logic       rdy_dn;
    logic       rdy_a, vld_a, fd_a;
    logic [7:0] edge_a;
    logic       rdy_b, vld_b, fd_b;
    logic [7:0] edge_b;

    always #5 clk = ~clk;

    sobel_edge_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .gray_i(gray), .valid_i(vin), .ready_o(rdy_a),
        .edge_o(edge_a), .valid_o(vld_a), .ready_i(rdy_dn), .frame_done_o(fd_a)
    );

    sobel_edge_stream #(.IMG_WIDTH(5), .IMG_HEIGHT(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .gray_i(gray), .valid_i(vin), .ready_o(rdy_b),
        .edge_o(edge_b), .valid_o(vld_b), .ready_i(1'b1), .frame_done_o(fd_b)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         bp_en = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int         fda = 0;
    int         fda_at = 0;
    int         fdb = 0;
    bit         hold = 1'b0;
    logic [7:0] hold_v = 8'd0;
    logic [7:0] fr [16];
    int         t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Downstream ready: always high, or a fixed 2-of-3 pattern when backpressure is enabled.
    initial begin
        rdy_dn = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1 rdy_dn = bp_en ? ((cyc % 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", vld_a, 1);
                chk("hold_edge", edge_a, hold_v);
            end
            if (vld_a && !rdy_dn) chk("stall_ready_o", rdy_a, 0);
            if (vld_a && rdy_dn) qa.push_back(edge_a);
            if (fd_a) begin
                fda++;
                fda_at = qa.size();
            end
            hold   = vld_a && !rdy_dn;
            hold_v = edge_a;
            if (vld_b) qb.push_back(edge_b);
            if (fd_b) fdb++;
        end
    end

    task automatic send(input logic [7:0] p);
        int g;
        gray = p;
        vin  = 1'b1;
        g    = 0;
        @(negedge clk);
        while (!rdy_a && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) chk("send_timeout", g, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) send(fr[i]);
    endtask

    task automatic do_reset();
        vin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        qa.delete();
        qb.delete();
        fda = 0;
        fda_at = 0;
        fdb = 0;
    endtask

    task automatic drain(input int n);
        int g;
        vin = 1'b0;
        g   = 0;
        while (qa.size() < n && g < 200) begin
            @(negedge clk);
            g++;
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] e [4];
        e = '{e0, e1, e2, e3};
        chk({tag, "_count"}, qa.size(), 4);
        for (int i = 0; i < qa.size() && i < 4; i++) chk({tag, "_val"}, qa[i], e[i]);
        chk({tag, "_frame_done"}, fda, 1);
        chk({tag, "_fd_on_last"}, fda_at, 4);
    endtask

    initial begin
        rst  = 1'b1;
        vin  = 1'b0;
        gray = 8'd0;
        do_reset();
        chk("rst_valid", vld_a, 0);
        chk("rst_edge", edge_a, 0);
        chk("rst_frame_done", fd_a, 0);
        chk("rst_ready", rdy_a, 1);

        // Uniform frame: flat image has no gradient.
        for (int i = 0; i < 16; i++) fr[i] = 8'd100;
        send_frame();
        drain(4);
        check4("uniform", 0, 0, 0, 0);

        // Vertical step 0|10: every interior window straddles it, 1-cycle latency checked per beat.
        do_reset();
        for (int i = 0; i < 16; i++) fr[i] = ((i % 4) >= 2) ? 8'd10 : 8'd0;
        for (int i = 0; i < 16; i++) begin
            send(fr[i]);
            chk("step_valid", vld_a, ((i / 4) >= 2) && ((i % 4) >= 2));
            if (((i / 4) >= 2) && ((i % 4) >= 2)) chk("step_edge", edge_a, 40);
        end
        drain(4);
        chk("step_frame_done", fda, 1);

        // Step 0|255 saturates (Gx=1020).
        do_reset();
        for (int i = 0; i < 16; i++) fr[i] = ((i % 4) >= 2) ? 8'd255 : 8'd0;
        send_frame();
        drain(4);
        check4("sat", 255, 255, 255, 255);

        // Sparse impulses under backpressure; last window has mag 300 -> 255.
        do_reset();
        for (int i = 0; i < 16; i++) fr[i] = 8'd0;
        fr[0]  = 8'd20;
        fr[5]  = 8'd50;
        fr[15] = 8'd200;
        bp_en = 1'b1;
        send_frame();
        drain(4);
        bp_en = 1'b0;
        check4("bp", 40, 100, 100, 255);

        // Mid-frame reset after 7 bright pixels, then a uniform frame.
        do_reset();
        for (int i = 0; i < 7; i++) send(8'd200);
        do_reset();
        chk("midrst_valid", vld_a, 0);
        for (int i = 0; i < 16; i++) fr[i] = 8'd50;
        send_frame();
        drain(4);
        check4("midrst", 0, 0, 0, 0);

        // Ramp 10*r+3*c then its inverse, back to back: |Gx|=24, |Gy|=80 in both.
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(8'((10 * (i / 4)) + (3 * (i % 4))));
        for (int i = 0; i < 16; i++) send(8'(255 - ((10 * (i / 4)) + (3 * (i % 4)))));
        chk("b2b_cycles", cyc - t0, 32);
        drain(8);
        chk("b2b_count", qa.size(), 8);
        for (int i = 0; i < qa.size() && i < 8; i++) chk("b2b_val", qa[i], 104);
        chk("b2b_frame_done", fda, 2);

        // 5x3 geometry: three outputs, only the last window sees the corner pixel.
        do_reset();
        for (int i = 0; i < 15; i++) send((i == 14) ? 8'd80 : 8'd0);
        vin = 1'b0;
        repeat (5) @(negedge clk);
        chk("w5h3_count", qb.size(), 3);
        if (qb.size() == 3) begin
            chk("w5h3_v0", qb[0], 0);
            chk("w5h3_v1", qb[1], 0);
            chk("w5h3_v2", qb[2], 160);
        end
        chk("w5h3_frame_done", fdb, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
